// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single data-memory port shared by the MEM stage and the debug unit
// Pipeline has priority; a bounded wait forces one debug cycle, and halt hands the port to debug.
module mem_port_arbiter #(
  parameter int BUS_SIZE  = 32,
  parameter int ADDR_SIZE = 5,
  parameter int MAX_WAIT  = 4,
  parameter int WAIT_W    = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_halt,
  input  logic                 i_pipe_req,
  input  logic                 i_pipe_wr,
  input  logic [ADDR_SIZE-1:0] i_pipe_addr,
  input  logic [BUS_SIZE-1:0]  i_pipe_wdata,
  output logic [BUS_SIZE-1:0]  o_pipe_rdata,
  output logic                 o_pipe_stall,
  input  logic                 i_dbg_valid,
  input  logic                 i_dbg_wr,
  input  logic [ADDR_SIZE-1:0] i_dbg_addr,
  input  logic [BUS_SIZE-1:0]  i_dbg_wdata,
  output logic                 o_dbg_ready,
  output logic                 o_dbg_rvalid,
  output logic [BUS_SIZE-1:0]  o_dbg_rdata,
  output logic                 o_mem_wr_rd,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [BUS_SIZE-1:0]  o_mem_wdata,
  input  logic [BUS_SIZE-1:0]  i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_PIPE  = 2'd0,
    ST_FORCE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                pipe_gnt;
  logic                dbg_gnt;
  logic                dbg_refused;
  logic                dbg_read_accept;

  // Reset forces the no-grant view so nothing reaches memory while it is held.
  always_comb begin
    pipe_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!i_reset) begin
      case (state)
        ST_PIPE: begin
          pipe_gnt = i_pipe_req;
          dbg_gnt  = !i_pipe_req && i_dbg_valid;
        end
        ST_FORCE: dbg_gnt = 1'b1;
        ST_HALT:  dbg_gnt = i_dbg_valid;
        default: begin
          pipe_gnt = 1'b0;
          dbg_gnt  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_mem_wr_rd = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (pipe_gnt) begin
      o_mem_wr_rd = i_pipe_wr;
      o_mem_addr  = i_pipe_addr;
      o_mem_wdata = i_pipe_wdata;
    end else if (dbg_gnt) begin
      o_mem_wr_rd = i_dbg_wr;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
    end
  end

  assign o_pipe_rdata    = i_mem_rdata;
  assign o_pipe_stall    = i_pipe_req && !pipe_gnt;
  assign o_dbg_ready     = dbg_gnt;
  assign dbg_refused     = i_dbg_valid && !dbg_gnt;
  assign dbg_read_accept = i_dbg_valid && dbg_gnt && !i_dbg_wr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_PIPE;
      wait_cnt     <= '0;
      o_dbg_rvalid <= 1'b0;
      o_dbg_rdata  <= '0;
    end else begin
      if (i_halt) begin
        state <= ST_HALT;
      end else begin
        case (state)
          ST_HALT:  state <= ST_PIPE;
          ST_FORCE: state <= ST_PIPE;
          ST_PIPE: begin
            if (dbg_refused && wait_cnt == WAIT_W'(MAX_WAIT - 1))
              state <= ST_FORCE;
          end
          default:  state <= ST_PIPE;
        endcase
      end

      if (!dbg_refused)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + WAIT_W'(1);

      o_dbg_rvalid <= dbg_read_accept;
      if (dbg_read_accept)
        o_dbg_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Reference model tracks halt ownership and the debug refusal streak, plus a shadow memory.
module tb_mem_port_arbiter;

  localparam int BUS   = 32;
  localparam int AW    = 5;
  localparam int MAXW  = 4;
  localparam int WW    = 3;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          i_reset, i_halt;
  logic          i_pipe_req, i_pipe_wr;
  logic [AW-1:0] i_pipe_addr;
  logic [BUS-1:0] i_pipe_wdata, o_pipe_rdata;
  logic          o_pipe_stall;
  logic          i_dbg_valid, i_dbg_wr;
  logic [AW-1:0] i_dbg_addr;
  logic [BUS-1:0] i_dbg_wdata;
  logic          o_dbg_ready, o_dbg_rvalid;
  logic [BUS-1:0] o_dbg_rdata;
  logic          o_mem_wr_rd;
  logic [AW-1:0] o_mem_addr;
  logic [BUS-1:0] o_mem_wdata, i_mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .BUS_SIZE(BUS), .ADDR_SIZE(AW), .MAX_WAIT(MAXW), .WAIT_W(WW)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_pipe_req(i_pipe_req), .i_pipe_wr(i_pipe_wr), .i_pipe_addr(i_pipe_addr),
    .i_pipe_wdata(i_pipe_wdata), .o_pipe_rdata(o_pipe_rdata), .o_pipe_stall(o_pipe_stall),
    .i_dbg_valid(i_dbg_valid), .i_dbg_wr(i_dbg_wr), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_ready(o_dbg_ready), .o_dbg_rvalid(o_dbg_rvalid),
    .o_dbg_rdata(o_dbg_rdata), .o_mem_wr_rd(o_mem_wr_rd), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  function automatic logic [BUS-1:0] init_val(int k);
    return 32'hA500_0000 | 32'(k);
  endfunction

  // Memory seen by the DUT
  logic [BUS-1:0] mem [DEPTH];
  logic           init_req = 1'b1;
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_val(k);
    end else if (o_mem_wr_rd) begin
      mem[o_mem_addr] <= o_mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic           m_halted = 1'b0;
  int             m_streak = 0;
  logic           m_rvalid = 1'b0;
  logic [BUS-1:0] m_rdata = '0;
  logic [BUS-1:0] ref_mem [DEPTH];
  logic           e_pg, e_dg, e_wr;
  logic [AW-1:0]  e_addr;
  logic [BUS-1:0] e_wdata;

  always_comb begin
    e_pg = 1'b0;
    e_dg = 1'b0;
    if (!i_reset) begin
      if (m_halted)              e_dg = i_dbg_valid;
      else if (m_streak >= MAXW) e_dg = 1'b1;
      else if (i_pipe_req)       e_pg = 1'b1;
      else                       e_dg = i_dbg_valid;
    end
    e_wr    = e_pg ? i_pipe_wr    : (e_dg ? i_dbg_wr    : 1'b0);
    e_addr  = e_pg ? i_pipe_addr  : (e_dg ? i_dbg_addr  : '0);
    e_wdata = e_pg ? i_pipe_wdata : (e_dg ? i_dbg_wdata : '0);
  end

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < DEPTH; k++) ref_mem[k] <= init_val(k);
    end else if (e_wr) begin
      ref_mem[e_addr] <= e_wdata;
    end
    if (i_reset) begin
      m_halted <= 1'b0;
      m_streak <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
    end else begin
      m_halted <= i_halt;
      m_streak <= (i_dbg_valid && !e_dg) ? ((m_streak < MAXW) ? m_streak + 1 : MAXW) : 0;
      m_rvalid <= i_dbg_valid && e_dg && !i_dbg_wr;
      if (i_dbg_valid && e_dg && !i_dbg_wr) m_rdata <= ref_mem[i_dbg_addr];
    end
  end

  always @(negedge clk) begin
    if (!init_req) begin
      chk("mem_wr_rd", 32'(o_mem_wr_rd), 32'(e_wr));
      chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
      chk("mem_wdata", o_mem_wdata, e_wdata);
      chk("pipe_stall", 32'(o_pipe_stall), 32'(i_pipe_req && !e_pg));
      chk("dbg_ready", 32'(o_dbg_ready), 32'(e_dg));
      chk("pipe_rdata", o_pipe_rdata, ref_mem[e_addr]);
      chk("dbg_rvalid", 32'(o_dbg_rvalid), 32'(m_rvalid));
      chk("dbg_rdata", o_dbg_rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic pipe(input logic req, input logic wr, input logic [AW-1:0] a, input logic [BUS-1:0] d);
    i_pipe_req = req; i_pipe_wr = wr; i_pipe_addr = a; i_pipe_wdata = d;
  endtask

  task automatic dbg(input logic v, input logic wr, input logic [AW-1:0] a, input logic [BUS-1:0] d);
    i_dbg_valid = v; i_dbg_wr = wr; i_dbg_addr = a; i_dbg_wdata = d;
  endtask

  function automatic logic [BUS-1:0] dump_val(int k);
    if (k == 3) return 32'hDEAD_BEEF;
    if (k == 7) return 32'h1234_5678;
    return init_val(k);
  endfunction

  task automatic starve(input logic [AW-1:0] a, input logic [BUS-1:0] exp_data);
    pipe(1'b1, 1'b0, 5'd0, '0);
    dbg(1'b1, 1'b0, a, '0);
    for (int c = 0; c < MAXW; c++) begin
      mid();
      chk("starve_refused_ready", 32'(o_dbg_ready), 32'd0);
      chk("starve_refused_stall", 32'(o_pipe_stall), 32'd0);
      tick();
    end
    mid();
    chk("force_ready", 32'(o_dbg_ready), 32'd1);
    chk("force_stall", 32'(o_pipe_stall), 32'd1);
    tick();
    dbg(1'b0, 1'b0, 5'd0, '0);
    mid();
    chk("post_force_stall", 32'(o_pipe_stall), 32'd0);
    chk("post_force_rvalid", 32'(o_dbg_rvalid), 32'd1);
    chk("post_force_rdata", o_dbg_rdata, exp_data);
    tick();
    pipe(1'b0, 1'b0, 5'd0, '0);
  endtask

  logic dbg_taken;

  initial begin
    i_reset = 1'b1;
    i_halt  = 1'b0;
    pipe(1'b0, 1'b0, 5'd0, '0);
    dbg(1'b0, 1'b0, 5'd0, '0);
    tick();
    tick();
    init_req = 1'b0;
    pipe(1'b1, 1'b1, 5'd9, 32'h5555_AAAA);
    mid();
    chk("reset_ready", 32'(o_dbg_ready), 32'd0);
    chk("reset_wr", 32'(o_mem_wr_rd), 32'd0);
    chk("reset_stall", 32'(o_pipe_stall), 32'd1);
    tick();
    i_reset = 1'b0;
    pipe(1'b0, 1'b0, 5'd0, '0);
    mid();
    chk("reset_rvalid", 32'(o_dbg_rvalid), 32'd0);
    chk("reset_rdata", o_dbg_rdata, 32'd0);
    tick();

    pipe(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    mid();
    chk("store_wr", 32'(o_mem_wr_rd), 32'd1);
    chk("store_addr", 32'(o_mem_addr), 32'd3);
    chk("store_stall", 32'(o_pipe_stall), 32'd0);
    tick();
    pipe(1'b1, 1'b0, 5'd3, '0);
    mid();
    chk("load_rdata", o_pipe_rdata, 32'hDEAD_BEEF);
    chk("load_wr", 32'(o_mem_wr_rd), 32'd0);
    chk("load_stall", 32'(o_pipe_stall), 32'd0);
    tick();

    pipe(1'b0, 1'b0, 5'd0, '0);
    dbg(1'b1, 1'b1, 5'd7, 32'h1234_5678);
    mid();
    chk("dbg_wr_ready", 32'(o_dbg_ready), 32'd1);
    tick();
    dbg(1'b1, 1'b0, 5'd7, '0);
    mid();
    chk("dbg_wr_no_rvalid", 32'(o_dbg_rvalid), 32'd0);
    chk("dbg_rd_ready", 32'(o_dbg_ready), 32'd1);
    tick();
    dbg(1'b0, 1'b0, 5'd0, '0);
    mid();
    chk("dbg_rd_rvalid", 32'(o_dbg_rvalid), 32'd1);
    chk("dbg_rd_rdata", o_dbg_rdata, 32'h1234_5678);
    tick();
    mid();
    chk("dbg_rvalid_pulse", 32'(o_dbg_rvalid), 32'd0);
    tick();

    starve(5'd7, 32'h1234_5678);

    i_halt = 1'b1;
    pipe(1'b1, 1'b0, 5'd0, '0);
    mid();
    chk("halt_entry_stall", 32'(o_pipe_stall), 32'd0);
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      dbg(1'b1, 1'b0, AW'(k), '0);
      mid();
      chk("dump_ready", 32'(o_dbg_ready), 32'd1);
      chk("dump_stall", 32'(o_pipe_stall), 32'd1);
      if (k > 0) begin
        chk("dump_rvalid", 32'(o_dbg_rvalid), 32'd1);
        chk("dump_rdata", o_dbg_rdata, dump_val(k - 1));
      end
      tick();
    end
    dbg(1'b0, 1'b0, 5'd0, '0);
    i_halt = 1'b0;
    pipe(1'b0, 1'b0, 5'd0, '0);
    mid();
    chk("dump_last_rvalid", 32'(o_dbg_rvalid), 32'd1);
    chk("dump_last_rdata", o_dbg_rdata, dump_val(DEPTH - 1));
    tick();

    dbg(1'b1, 1'b0, 5'd3, '0);
    i_reset = 1'b1;
    mid();
    chk("rst_mid_ready", 32'(o_dbg_ready), 32'd0);
    tick();
    i_reset = 1'b0;
    dbg(1'b0, 1'b0, 5'd0, '0);
    mid();
    chk("rst_mid_rvalid", 32'(o_dbg_rvalid), 32'd0);
    chk("rst_mid_rdata", o_dbg_rdata, 32'd0);
    tick();
    starve(5'd3, 32'hDEAD_BEEF);

    pipe(1'b0, 1'b0, 5'd0, '0);
    dbg(1'b0, 1'b0, 5'd0, '0);
    mid();
    chk("idle_wr", 32'(o_mem_wr_rd), 32'd0);
    chk("idle_addr", 32'(o_mem_addr), 32'd0);
    chk("idle_wdata", o_mem_wdata, 32'd0);
    chk("idle_stall", 32'(o_pipe_stall), 32'd0);
    chk("idle_ready", 32'(o_dbg_ready), 32'd0);
    tick();
    mid();
    chk("idle_mem3", mem[3], 32'hDEAD_BEEF);
    chk("idle_mem7", mem[7], 32'h1234_5678);
    tick();

    dbg_taken = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      i_reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) i_halt = !i_halt;
      pipe($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom);
      if (!i_dbg_valid || dbg_taken)
        dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom);
      mid();
      dbg_taken = i_dbg_valid && e_dg;
      tick();
    end

    i_reset = 1'b0;
    i_halt  = 1'b0;
    pipe(1'b0, 1'b0, 5'd0, '0);
    dbg(1'b0, 1'b0, 5'd0, '0);
    tick();
    mid();
    for (int k = 0; k < DEPTH; k++) chk("final_mem", mem[k], ref_mem[k]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
